r4_mdc_commutator: RTL and testbench
====================================

Name: r4_mdc_commutator

Overview:
Parametrised radix-4 multi-path delay commutator for the MDC FFT pipeline. It sits between a twiddle (Hadamard) stage and the next radix-4 butterfly (GEMM) stage. It performs the 4x4 transpose of D-sample groups across the four lanes, where D = DEPTH, and is generic over data width and group depth. Unlike the fixed-stage commutators, it has valid-qualified stalling, frame sync, fill tracking, an output start-of-frame marker, and a latency-matched bypass mode.

Parameters:
WIDTH, 16, bit width of one real or imaginary sample (SFP word). One instance carries one component.
DEPTH, 2, group depth D in samples. Power of two, 1..64.
LANES, 4, lane count. Fixed at 4; any other value is a compile-time error.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  reset, asynchronous assert, active-low
in_valid_i  in  1  input beat valid; pipeline advances only on valid beats
sync_i  in  1  qualified by in_valid_i; marks beat 0 of a frame
bypass_i  in  1  sampled only on sync beats; 1 = pass lanes straight through
data_i  in  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
out_valid_o  out  1  output beat valid
out_sof_o  out  1  output beat is offset 0 of group 0 of a frame
data_o  out  LANES*WIDTH  lane packing as data_i

Behaviour:
- Reset values: out_valid_o=0, out_sof_o=0, data_o=0. All counters and delay registers clear to 0. The latched mode clears to 0 (commutate).
- Accepted beat = cycle with in_valid_i=1. No accepted beat means full stall: no counter, delay line or output register changes. out_valid_o drops to 0 on the following cycle.
- Frame = 4*D accepted beats, as groups g=0..3 of D beats with offset t=0..D-1. Input sample x[k][g][t] is on lane k.
- Transpose: output lane k, group g, offset t = x[g][k][t].
- Latency: exactly 3*D accepted beats. The output for accepted beat n is registered on the edge that accepts beat n+3D, so it is visible in the cycle after.
- Bypass: output lane k = input lane k, same 3*D latency, same valid/sof timing. The mode latched at a sync beat applies to every output beat of that frame. Frames in different modes may run back to back.
- Phase counter: 0..4D-1, incremented per accepted beat, wraps to 0, and is forced to 0 on a sync beat. Switch select is phase/D.
- Structure: input lane k is delayed k*D beats; a rotating 4x4 switch follows; output lane k is then delayed (3-k)*D beats.
- Fill counter: saturates at 3D and counts accepted beats since reset or last sync.
  - out_valid_o=1 the cycle after an accepted beat taken with fill==3D.
  - A sync beat resets fill to 0, so the previous partial frame's tail is discarded. out_valid_o stays low for the next 3D accepted beats.
- out_sof_o=1 with out_valid_o when the output beat maps to phase 0 of a frame.
- Continuous mode: after a sync, frames stream back to back with no further sync needed; the phase wrap marks frame boundaries.
- A sync beat with phase already 0 has no effect other than resetting fill.
- Reset mid-frame: everything returns to reset state immediately (async). The first output after deassertion requires a new sync plus 3D beats.
- No arithmetic is performed on data; width is preserved bit-exactly.

Decomposition:
- Package fft_mdc_pkg holds:
  - sfp_t typedef (logic [SFP_WIDTH-1:0]);
  - LANES=4;
  - a function for phase-to-switch-select.
- Sub-module mdc_delay_line (params WIDTH, LEN; enable; LEN=0 is a wire). It is instantiated per lane for the input and output delays.
- Top holds counters, mode latch, switch, and the output register.

Test Plan:
1. D=2, sync on beat 0, continuous valid, x[k][g][t]=16k+4g+t.
   - out_valid_o first high at cycle 7.
   - Lane 0 sequence 0x00,0x01,0x10,0x11,0x20,0x21,0x30,0x31; lane 3 sequence 0x0C,0x0D,0x1C,0x1D,...
   - out_sof_o only on the first beat.
2. Same frame with in_valid_i toggling 1,0 per cycle.
   - Identical output value sequence.
   - out_valid_o high only on cycles after accepted beats; first high after the 7th accepted beat.
3. Three back-to-back frames, single sync.
   - Outputs are contiguous after fill.
   - out_sof_o every 8 output beats; data correct for each frame.
4. bypass_i=1 at sync, D=4. Output lane k equals input lane k delayed 12 accepted beats. Next frame with bypass_i=0 is transposed correctly with no gap.
5. Sync asserted at phase 5 mid-frame (D=2). out_valid_o low for the next 6 accepted beats, then a correctly transposed new frame.
6. rst_ni pulsed low mid-frame. All outputs 0 asynchronously and no out_valid_o until a sync plus 3D beats. Repeat scenario 1 with D=1 and D=8.

Source files
------------

// File: rtl/fft_mdc_pkg.sv
// Shared types, constants and helpers for the radix-4 MDC FFT pipeline.
package fft_mdc_pkg;

    localparam int SFP_WIDTH = 16;
    localparam int LANES     = 4;

    typedef logic [SFP_WIDTH-1:0] sfp_t;

    // Frame mode latched on a sync beat.
    typedef enum logic {
        MODE_COMMUTATE = 1'b0,
        MODE_BYPASS    = 1'b1
    } mode_e;

    // Switch select is the group index of the current phase, i.e. phase / depth.
    function automatic logic [1:0] phaseToSel(input int unsigned phase, input int unsigned depth);
        int unsigned grp;
        grp = phase / depth;
        return grp[1:0];
    endfunction

    // Input lane feeding output lane 'lane' when the switch select is 'sel'.
    function automatic logic [1:0] laneSrc(input logic [1:0] sel, input logic [1:0] lane);
        return sel - lane;
    endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// Enable-gated shift register delaying a word by LEN accepted beats; LEN=0 is a plain wire.
module mdc_delay_line #(
    parameter int WIDTH = 16,
    parameter int LEN   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (LEN == 0) begin : gWire
        logic unusedInputs;
        assign unusedInputs = &{1'b0, clk_i, rst_ni, en_i};
        assign q_o = d_i;
    end else begin : gShift
        logic [WIDTH-1:0] stage_q [LEN];

        // Shift one position per accepted beat; hold everything during a stall.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s < LEN; s++) stage_q[s] <= '0;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int s = 1; s < LEN; s++) stage_q[s] <= stage_q[s-1];
            end
        end

        assign q_o = stage_q[LEN-1];
    end

endmodule

// File: rtl/r4_mdc_commutator.sv
// Radix-4 MDC commutator: 4x4 transpose of DEPTH-beat groups across four lanes,
// with valid-qualified stalling, frame sync, fill tracking, SOF marker and bypass.
module r4_mdc_commutator #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    input  logic                   sync_i,
    input  logic                   bypass_i,
    input  logic [LANES*WIDTH-1:0] data_i,
    output logic                   out_valid_o,
    output logic                   out_sof_o,
    output logic [LANES*WIDTH-1:0] data_o
);

    import fft_mdc_pkg::*;

    if (LANES != fft_mdc_pkg::LANES) begin : gLanesCheck
        $error("r4_mdc_commutator supports exactly 4 lanes");
    end
    if (DEPTH < 1 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
        $error("r4_mdc_commutator DEPTH must be a power of two in 1..64");
    end

    localparam int FRAME = 4 * DEPTH;
    localparam int PW    = $clog2(FRAME);
    localparam logic [PW-1:0] LAST_PHASE = PW'(FRAME - 1);
    localparam logic [PW-1:0] FILL_MAX   = PW'(3 * DEPTH);
    localparam logic [PW-1:0] SOF_PHASE  = PW'(3 * DEPTH);

    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] fill_q, fill_d;
    mode_e         mode_q, mode_d;
    logic          outValid_q, outValid_d;
    logic          outSof_q, outSof_d;
    logic [LANES*WIDTH-1:0] outData_q, outData_d;

    logic          syncBeat;
    logic [PW-1:0] phaseCur;
    logic [PW-1:0] fillCur;
    mode_e         modeCur;
    logic [1:0]    sel;

    logic [WIDTH:0]   inDly  [LANES];
    logic [WIDTH-1:0] swOut  [LANES];
    logic [WIDTH-1:0] outDly [LANES];

    // A sync beat restarts the frame at phase 0, empties the fill count and takes a new mode.
    assign syncBeat = in_valid_i & sync_i;
    assign phaseCur = syncBeat ? '0 : phase_q;
    assign fillCur  = syncBeat ? '0 : fill_q;
    assign modeCur  = syncBeat ? mode_e'(bypass_i) : mode_q;

    // Each input lane k is delayed k*DEPTH beats; the mode bit travels with the data so
    // every lane leaves the switch using the mode of the frame it belongs to.
    for (genvar k = 0; k < LANES; k++) begin : gInDly
        mdc_delay_line #(
            .WIDTH (WIDTH + 1),
            .LEN   (k * DEPTH)
        ) uInDly (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (in_valid_i),
            .d_i    ({modeCur == MODE_BYPASS, data_i[k*WIDTH +: WIDTH]}),
            .q_o    (inDly[k])
        );
    end

    // Rotating switch: output lane k takes input lane (sel - k) mod 4, or lane k itself in bypass.
    always_comb begin
        sel = phaseToSel(32'(phaseCur), DEPTH);
        for (int k = 0; k < LANES; k++) begin
            swOut[k] = inDly[k][WIDTH] ? inDly[k][WIDTH-1:0]
                                       : inDly[laneSrc(sel, 2'(k))][WIDTH-1:0];
        end
    end

    // Each output lane k is delayed (3-k)*DEPTH beats so every path totals 3*DEPTH.
    for (genvar k = 0; k < LANES; k++) begin : gOutDly
        mdc_delay_line #(
            .WIDTH (WIDTH),
            .LEN   ((3 - k) * DEPTH)
        ) uOutDly (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (in_valid_i),
            .d_i    (swOut[k]),
            .q_o    (outDly[k])
        );
    end

    // Next-state for counters, mode latch and output register; nothing moves without a valid beat.
    always_comb begin
        phase_d    = phase_q;
        fill_d     = fill_q;
        mode_d     = mode_q;
        outValid_d = 1'b0;
        outSof_d   = 1'b0;
        outData_d  = outData_q;
        if (in_valid_i) begin
            phase_d    = (phaseCur == LAST_PHASE) ? '0 : phaseCur + PW'(1);
            fill_d     = (fillCur == FILL_MAX) ? fillCur : fillCur + PW'(1);
            mode_d     = modeCur;
            outValid_d = (fillCur == FILL_MAX);
            outSof_d   = (fillCur == FILL_MAX) && (phaseCur == SOF_PHASE);
            for (int k = 0; k < LANES; k++) outData_d[k*WIDTH +: WIDTH] = outDly[k];
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= '0;
            fill_q     <= '0;
            mode_q     <= MODE_COMMUTATE;
            outValid_q <= 1'b0;
            outSof_q   <= 1'b0;
            outData_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            fill_q     <= fill_d;
            mode_q     <= mode_d;
            outValid_q <= outValid_d;
            outSof_q   <= outSof_d;
            outData_q  <= outData_d;
        end
    end

    assign out_valid_o = outValid_q;
    assign out_sof_o   = outSof_q;
    assign data_o      = outData_q;

endmodule

// File: tb/tb_r4_mdc_commutator.sv
// Scoreboard bench for r4_mdc_commutator at DEPTH = 1, 2, 4 and 8.
module tb_r4_mdc_commutator;

    localparam int W  = 16;
    localparam int NI = 4;
    localparam int DW = 4 * W;

    typedef logic [DW:0] item_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          validA   [NI];
    logic          syncA    [NI];
    logic          bypA     [NI];
    logic [DW-1:0] dataA    [NI];
    logic          outValidA[NI];
    logic          outSofA  [NI];
    logic [DW-1:0] outDataA [NI];

    item_t         expQ    [NI][$];
    logic [DW-1:0] hist    [NI][$];
    bit            epochByp[NI];
    bit            expValid[NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : gDut
        r4_mdc_commutator #(
            .WIDTH (W),
            .DEPTH (1 << gi),
            .LANES (4)
        ) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (validA[gi]),
            .sync_i      (syncA[gi]),
            .bypass_i    (bypA[gi]),
            .data_i      (dataA[gi]),
            .out_valid_o (outValidA[gi]),
            .out_sof_o   (outSofA[gi]),
            .data_o      (outDataA[gi])
        );
    end

    // Reference model: all accepted beats since the last sync are kept; output n of the
    // epoch is due with accepted beat n+3D and is built straight from the transpose rule.
    task automatic modelBeat(input int i, input bit s, input bit byp, input logic [DW-1:0] d);
        int D, j, n, f, p, g, t;
        logic [DW-1:0] e;
        logic [DW-1:0] src;
        D = 1 << i;
        if (s) begin
            hist[i].delete();
            epochByp[i] = byp;
        end
        hist[i].push_back(d);
        j = hist[i].size() - 1;
        if (j >= 3 * D) begin
            n = j - 3 * D;
            f = n / (4 * D);
            p = n % (4 * D);
            g = p / D;
            t = p % D;
            for (int k = 0; k < 4; k++) begin
                if (epochByp[i]) begin
                    src = hist[i][n];
                    e[k*W +: W] = src[k*W +: W];
                end else begin
                    src = hist[i][f*4*D + k*D + t];
                    e[k*W +: W] = src[g*W +: W];
                end
            end
            expQ[i].push_back({(p == 0), e});
            expValid[i] = 1'b1;
        end
    endtask

    // Drive one cycle on instance i (all others idle) and record what the model expects.
    task automatic applyStimulus(input int i, input bit v, input bit s, input bit byp, input logic [DW-1:0] d);
        for (int j = 0; j < NI; j++) validA[j] = 1'b0;
        validA[i] = v;
        syncA[i]  = s;
        bypA[i]   = byp;
        dataA[i]  = d;
        @(posedge clk);
        for (int j = 0; j < NI; j++) expValid[j] = 1'b0;
        if (v) modelBeat(i, s, byp, d);
        #2;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Recognisable pattern: lane k, group g, offset t carries 16k+4g+t.
    function automatic logic [DW-1:0] patData(input int D, input int j);
        int p, g, t;
        logic [DW-1:0] r;
        p = j % (4 * D);
        g = p / D;
        t = p % D;
        for (int k = 0; k < 4; k++) r[k*W +: W] = 16'(16 * k + 4 * g + t);
        return r;
    endfunction

    // One epoch: a sync on the first accepted beat, then nBeats-1 more accepted beats.
    // validMode 0 = every cycle, 1 = alternating, 2 = random. Idle cycles carry junk sync/bypass.
    task automatic runEpoch(input int i, input int nBeats, input bit byp, input int validMode, input bit patterned);
        int acc;
        int cyc;
        bit v;
        logic [DW-1:0] d;
        acc = 0;
        cyc = 0;
        while (acc < nBeats) begin
            case (validMode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 9) < 6);
            endcase
            if (v) begin
                d = patterned ? patData(1 << i, acc) : {$urandom, $urandom};
                applyStimulus(i, 1'b1, acc == 0, (acc == 0) ? byp : 1'($urandom_range(0, 1)), d);
                acc++;
            end else begin
                applyStimulus(i, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            end
            cyc++;
        end
    endtask

    // Assert reset between clock edges and clear the model.
    task automatic pulseReset();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            hist[i].delete();
            expQ[i].delete();
            expValid[i] = 1'b0;
            epochByp[i] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic checkReset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (outValidA[i] !== 1'b0 || outSofA[i] !== 1'b0 || outDataA[i] !== '0) begin
                errors++;
                $display("[TB] FAIL reset D=%0d got valid=%b sof=%b data=%h want all zero",
                         1 << i, outValidA[i], outSofA[i], outDataA[i]);
            end
        end
    endtask

    task automatic checkOutput(input int i);
        item_t e;
        checks++;
        if (outValidA[i] !== expValid[i]) begin
            errors++;
            $display("[TB] FAIL valid D=%0d at %0t got %b want %b", 1 << i, $time, outValidA[i], expValid[i]);
        end
        if (expValid[i] && expQ[i].size() > 0) begin
            e = expQ[i].pop_front();
            if (outValidA[i] === 1'b1) begin
                checks++;
                if (outDataA[i] !== e[DW-1:0]) begin
                    errors++;
                    $display("[TB] FAIL data D=%0d at %0t got %h want %h", 1 << i, $time, outDataA[i], e[DW-1:0]);
                end
                checks++;
                if (outSofA[i] !== e[DW]) begin
                    errors++;
                    $display("[TB] FAIL sof D=%0d at %0t got %b want %b", 1 << i, $time, outSofA[i], e[DW]);
                end
            end
        end
    endtask

    // Monitor: outputs must be zero shortly after reset falls; otherwise compare every
    // instance against the scoreboard once per cycle, away from the active edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            checkReset();
        end else begin
            for (int i = 0; i < NI; i++) checkOutput(i);
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            validA[i]   = 1'b0;
            syncA[i]    = 1'b0;
            bypA[i]     = 1'b0;
            dataA[i]    = '0;
            expValid[i] = 1'b0;
            epochByp[i] = 1'b0;
        end
        #3;
        checkReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        $display("[TB] D=2 single patterned frame, continuous then alternating valid");
        runEpoch(1, 14, 1'b0, 0, 1'b1);
        runEpoch(1, 14, 1'b0, 1, 1'b1);

        $display("[TB] D=2 three back-to-back frames on one sync");
        runEpoch(1, 30, 1'b0, 0, 1'b0);

        $display("[TB] D=2 resync at phase 5");
        runEpoch(1, 5, 1'b0, 0, 1'b0);
        runEpoch(1, 14, 1'b0, 0, 1'b1);

        $display("[TB] D=2 reset mid-frame");
        runEpoch(1, 10, 1'b0, 0, 1'b0);
        pulseReset();
        idle(3);
        runEpoch(1, 14, 1'b0, 0, 1'b1);

        $display("[TB] D=4 bypass frame then commutated frame");
        runEpoch(2, 28, 1'b1, 0, 1'b0);
        runEpoch(2, 28, 1'b0, 0, 1'b0);
        runEpoch(2, 40, 1'b1, 2, 1'b0);

        $display("[TB] D=1 and D=8");
        runEpoch(0, 7, 1'b0, 0, 1'b1);
        runEpoch(0, 20, 1'b0, 2, 1'b0);
        runEpoch(0, 10, 1'b1, 0, 1'b0);
        runEpoch(3, 56, 1'b0, 0, 1'b1);
        runEpoch(3, 60, 1'b0, 2, 1'b0);
        runEpoch(3, 40, 1'b1, 1, 1'b0);

        $display("[TB] random epochs");
        repeat (12) begin
            runEpoch($urandom_range(0, 3), $urandom_range(3, 60), 1'($urandom_range(0, 1)), 2, 1'b0);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
